// File: rtl/data_memory.sv
// Byte-addressed data memory behind the ALU: lb/lbu/lh/lhu/lw, sb/sh/sw.
// Combinational loads, synchronous byte-enabled stores, sticky fault capture.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              fault_o,
  output logic              err_o,
  output logic [31:0]       err_addr_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              access;
  logic              bad_size;
  logic              oor;
  logic [DATA_W-1:0] word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_al;
  logic              do_write;

  assign idx    = addr_i[ADDR_W+1:2];
  assign lane   = addr_i[1:0];
  assign access = mem_read_i | mem_write_i;
  assign oor    = |addr_i[31:ADDR_W+2];
  assign word   = mem[idx];

  always_comb begin
    bad_size = 1'b0;
    unique case (size_i)
      2'b00:   bad_size = 1'b0;
      2'b01:   bad_size = lane[0];
      2'b10:   bad_size = |lane;
      default: bad_size = 1'b1;
    endcase
  end

  assign fault_o = access &
    (bad_size | oor | (mem_read_i & mem_write_i));

  assign do_write = mem_write_i & ~fault_o;

  always_comb begin
    byte_sel = word[7:0];
    unique case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
    endcase
  end

  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata_o = '0;
    if (rst_ni && mem_read_i && !fault_o) begin
      unique case (size_i)
        2'b00: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        2'b01: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        default: rdata_o = word;
      endcase
    end
  end

  // Replicate store data across lanes; byte enables pick the live ones.
  always_comb begin
    be       = 4'b0000;
    wdata_al = wdata_i;
    unique case (size_i)
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_al = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
    end
  end

  // A new fault outranks a clear; only the first address is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (fault_o) begin
      err_o <= 1'b1;
      if (!err_o) err_addr_o <= addr_i;
    end else if (err_clr_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// One task per scenario; expected values are hand-computed constants.
module tb_data_memory;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic        err_clr_i;
  logic [31:0] rdata_o;
  logic        fault_o;
  logic        err_o;
  logic [31:0] err_addr_o;

  int total = 0;
  int bad = 0;

  data_memory #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i),
    .wdata_i(wdata_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .err_clr_i(err_clr_i),
    .rdata_o(rdata_o), .fault_o(fault_o), .err_o(err_o),
    .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read_i  = rd;
    mem_write_i = wr;
    size_i      = sz;
    unsigned_i  = uns;
    addr_i      = a;
    wdata_i     = d;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    err_clr_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    err_clr_i = 1'b0;
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata_o, 32'h0);
    end
    total++;
    if (err_o !== 1'b0 || err_addr_o !== 32'h0) begin
      bad++; $display("FAIL reset_err got=%b/%h exp=0/0", err_o, err_addr_o);
    end
    cyc();
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
  endtask

  task automatic test_word();
    drive(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    cyc();
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'hDEADBEEF || fault_o !== 1'b0) begin
      bad++; $display("FAIL lw_10 got=%h/%b exp=deadbeef/0", rdata_o, fault_o);
    end
  endtask

  task automatic test_byte();
    drive(0, 1, 2'b00, 0, 32'h11, 32'h000000AA);
    cyc();
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'hDEADAAEF) begin
      bad++; $display("FAIL sb_lw got=%h exp=deadaaef", rdata_o);
    end
    drive(1, 0, 2'b00, 0, 32'h11, 32'h0);
    total++;
    if (rdata_o !== 32'hFFFFFFAA) begin
      bad++; $display("FAIL lb_11 got=%h exp=ffffffaa", rdata_o);
    end
    drive(1, 0, 2'b00, 1, 32'h11, 32'h0);
    total++;
    if (rdata_o !== 32'h000000AA) begin
      bad++; $display("FAIL lbu_11 got=%h exp=000000aa", rdata_o);
    end
  endtask

  task automatic test_half();
    drive(0, 1, 2'b01, 0, 32'h12, 32'h00001234);
    cyc();
    drive(1, 0, 2'b01, 0, 32'h12, 32'h0);
    total++;
    if (rdata_o !== 32'h00001234) begin
      bad++; $display("FAIL lh_12 got=%h exp=00001234", rdata_o);
    end
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h1234AAEF) begin
      bad++; $display("FAIL sh_lw got=%h exp=1234aaef", rdata_o);
    end
    drive(0, 1, 2'b10, 0, 32'h10, 32'h00008001);
    cyc();
    drive(1, 0, 2'b01, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'hFFFF8001) begin
      bad++; $display("FAIL lh_10 got=%h exp=ffff8001", rdata_o);
    end
    drive(1, 0, 2'b01, 1, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h00008001) begin
      bad++; $display("FAIL lhu_10 got=%h exp=00008001", rdata_o);
    end
  endtask

  task automatic test_fault();
    drive(1, 0, 2'b10, 0, 32'h13, 32'h0);
    total++;
    if (fault_o !== 1'b1 || rdata_o !== 32'h0) begin
      bad++; $display("FAIL lw_13 got=%b/%h exp=1/0", fault_o, rdata_o);
    end
    cyc();
    total++;
    if (err_o !== 1'b1 || err_addr_o !== 32'h13) begin
      bad++; $display("FAIL err_13 got=%b/%h exp=1/13", err_o, err_addr_o);
    end
    drive(0, 1, 2'b10, 0, 32'h401, 32'hFFFFFFFF);
    total++;
    if (fault_o !== 1'b1) begin
      bad++; $display("FAIL oor_fault got=%b exp=1", fault_o);
    end
    cyc();
    total++;
    if (err_addr_o !== 32'h13) begin
      bad++; $display("FAIL err_keep got=%h exp=13", err_addr_o);
    end
    drive(1, 0, 2'b10, 0, 32'h0, 32'h0);
    total++;
    if (rdata_o !== 32'h0) begin
      bad++; $display("FAIL oor_nowr0 got=%h exp=0", rdata_o);
    end
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h00008001) begin
      bad++; $display("FAIL oor_nowr10 got=%h exp=00008001", rdata_o);
    end
    drive(0, 0, 2'b11, 0, 32'h13, 32'h0);
    total++;
    if (fault_o !== 1'b0) begin
      bad++; $display("FAIL idle_fault got=%b exp=0", fault_o);
    end
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    total++;
    if (err_o !== 1'b0 || err_addr_o !== 32'h0) begin
      bad++; $display("FAIL clr got=%b/%h exp=0/0", err_o, err_addr_o);
    end
  endtask

  task automatic test_clear_vs_fault();
    err_clr_i = 1'b1;
    drive(0, 1, 2'b01, 0, 32'h21, 32'hFFFF);
    cyc();
    err_clr_i = 1'b0;
    total++;
    if (err_o !== 1'b1 || err_addr_o !== 32'h21) begin
      bad++; $display("FAIL clr_vs_fault got=%b/%h exp=1/21", err_o, err_addr_o);
    end
    drive(1, 1, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (fault_o !== 1'b1 || rdata_o !== 32'h0) begin
      bad++; $display("FAIL rdwr_fault got=%b/%h exp=1/0", fault_o, rdata_o);
    end
    cyc();
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h00008001 || err_addr_o !== 32'h21) begin
      bad++; $display("FAIL rdwr_nowr got=%h/%h exp=00008001/21", rdata_o, err_addr_o);
    end
    drive(1, 0, 2'b11, 0, 32'h10, 32'h0);
    total++;
    if (fault_o !== 1'b1) begin
      bad++; $display("FAIL rsvd_size got=%b exp=1", fault_o);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 2'b00, 0, 32'h30, 32'h00000044);
    cyc();
    drive(0, 1, 2'b00, 0, 32'h31, 32'h00000033);
    cyc();
    drive(0, 1, 2'b01, 0, 32'h32, 32'h00001122);
    cyc();
    drive(1, 0, 2'b10, 0, 32'h30, 32'h0);
    total++;
    if (rdata_o !== 32'h11223344) begin
      bad++; $display("FAIL b2b got=%h exp=11223344", rdata_o);
    end
    drive(1, 0, 2'b00, 0, 32'h33, 32'h0);
    total++;
    if (rdata_o !== 32'h00000011) begin
      bad++; $display("FAIL lb_33 got=%h exp=00000011", rdata_o);
    end
  endtask

  task automatic test_reset_mid_write();
    drive(0, 1, 2'b10, 0, 32'h20, 32'h55AA55AA);
    #2;
    rst_ni = 1'b0;
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h0 || err_o !== 1'b0) begin
      bad++; $display("FAIL rst_hold got=%h/%b exp=0/0", rdata_o, err_o);
    end
    cyc();
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1, 0, 2'b10, 0, 32'h20, 32'h0);
    total++;
    if (rdata_o !== 32'h0) begin
      bad++; $display("FAIL rst_lw20 got=%h exp=0", rdata_o);
    end
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    total++;
    if (rdata_o !== 32'h0 || err_addr_o !== 32'h0) begin
      bad++; $display("FAIL rst_lw10 got=%h/%h exp=0/0", rdata_o, err_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_clear_vs_fault();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory stage directly downstream of the N-bit ALU in the single-cycle datapath.
- The ALU result is the byte address; supports lb/lbu/lh/lhu/lw loads and sb/sh/sw stores.
- Reads are combinational; writes are synchronous with byte enables.
- Holds a sticky fault register, with captured address, for misaligned, out-of-range and illegal accesses.

Parameters:
DATA_W, 32, data word width; fixed at 32, other values unsupported.
ADDR_W, 8, word-index bits; depth = 2**ADDR_W words (default 256 words = 1 KiB).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
addr_i  input  32  byte address (ALU salida_o).
wdata_i  input  32  store data (rt register).
mem_read_i  input  1  load request.
mem_write_i  input  1  store request.
size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
unsigned_i  input  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
err_clr_i  input  1  clears sticky fault on next edge.
rdata_o  output  32  load data, extended.
fault_o  output  1  current access faults (combinational).
err_o  output  1  sticky fault flag.
err_addr_o  output  32  address of first faulting access since clear.

Behaviour:
- Reset (rst_ni=0, async):
  - Every memory word = 0, err_o = 0, err_addr_o = 0.
  - rdata_o = 0 while reset is held.
  - Reset mid-write: the write is discarded.
- Little-endian. Word index = addr_i[ADDR_W+1:2]; byte lane = addr_i[1:0].
- Fault conditions (fault_o=1 only when mem_read_i|mem_write_i):
  - halfword with addr_i[0]=1;
  - word with addr_i[1:0]≠00;
  - size_i=11;
  - addr_i[31:ADDR_W+2] ≠ 0 (out of range);
  - mem_read_i & mem_write_i both 1.
- Load (combinational, 0-cycle latency):
  - mem_read_i=1 and no fault: rdata_o = selected lane(s), extended per unsigned_i. unsigned_i is ignored for word.
  - Byte: lane addr[1:0]. Halfword: bytes {2*addr[1]+1, 2*addr[1]}.
  - Otherwise rdata_o = 0.
- Store (rising edge): mem_write_i=1 and no fault:
  - Byte: wdata_i[7:0] written to lane addr[1:0] only.
  - Halfword: wdata_i[15:0] written to lanes 2*addr[1] and 2*addr[1]+1.
  - Word: all four lanes.
  - Unselected lanes are preserved.
  - A faulting store writes nothing.
- Read-during-write to the same address in one cycle: rdata_o shows the old contents before the edge and the new contents after it.
- Sticky fault, evaluated at each edge:
  - If fault_o=1: err_o ← 1; err_addr_o ← addr_i only if err_o was 0 (first fault is kept).
  - Else if err_clr_i=1: err_o ← 0, err_addr_o ← 0.
  - Simultaneous err_clr_i and new fault: the fault wins. err_addr_o ← addr_i only if err_o was 0 before the edge; otherwise the earlier address is kept.
- Idle cycle (no read, no write): no state change except err_clr_i handling; fault_o = 0.

Test Plan:
1. Reset, then sw addr=0x00000010 wdata=0xDEADBEEF; next cycle lw 0x10 -> rdata_o=0xDEADBEEF, fault_o=0.
2. After 1: sb 0x11 wdata=0x000000AA; lw 0x10 -> 0xDEADAAEF. lb 0x11 -> 0xFFFFFFAA; lbu 0x11 -> 0x000000AA.
3. After 2: sh 0x12 wdata=0x00001234; lh 0x12 -> 0x00001234, lw 0x10 -> 0x1234AAEF. lh 0x10 with word 0x0000_8001 -> 0xFFFF8001; lhu -> 0x00008001.
4. lw 0x13 (misaligned) -> fault_o=1, rdata_o=0, err_o=1, err_addr_o=0x13 after edge. Then sw 0x00000401 (out of range, ADDR_W=8) -> memory unchanged, err_addr_o stays 0x13. err_clr_i=1 on an idle cycle -> err_o=0, err_addr_o=0.
5. err_clr_i=1 together with sh 0x21 (misaligned) -> err_o=1, err_addr_o=0x21. mem_read_i=mem_write_i=1 at 0x10 -> fault, no write.
6. Store 0x55AA55AA to 0x20, assert rst_ni=0 mid-cycle -> lw 0x20 after reset = 0, err_o=0, rdata_o=0 during reset.
